// File: rtl/vga_plot_sequencer.sv
// Purpose: buffers pixel plot commands and full-screen clear requests, then
//   writes them to a VGA adapter at one pixel per cycle through a registered port.
// Latency: a command accepted at edge N into an empty FIFO is on vga_* with
//   vga_plot=1 during the cycle after edge N+2. A clear writes X_LIMIT*Y_LIMIT
//   pixels back to back.
// Backpressure: plot_ready falls when the FIFO is full, when a clear is pending,
//   or while the clear sweep runs. It never depends on a pop in the same cycle.
// Ports: clock, resetn (synchronous, active-low);
//   plot_valid/plot_ready/plot_x/plot_y/plot_color form the command handshake;
//   clear_start/clear_color request a clear; busy and range_error report status;
//   vga_x/vga_y/vga_color/vga_plot form the adapter write port.
module vga_plot_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int X_LIMIT    = 160,
  parameter int Y_LIMIT    = 120
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        plot_valid,
  output logic        plot_ready,
  input  logic [7:0]  plot_x,
  input  logic [6:0]  plot_y,
  input  logic [14:0] plot_color,
  input  logic        clear_start,
  input  logic [14:0] clear_color,
  output logic        busy,
  output logic        range_error,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [14:0] vga_color,
  output logic        vga_plot
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  state_t        state;
  state_t        state_nxt;

  // Command FIFO. Entries are packed {x, y, color}.
  logic [29:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic [29:0]   rd_dat;
  logic [7:0]    rd_x;
  logic [6:0]    rd_y;
  logic          in_range;

  // Clear sequencing
  logic          clr_pend;
  logic          clr_wr;      // the pixel now on vga_* belongs to a clear sweep
  logic [7:0]    cx;
  logic [6:0]    cy;
  logic [14:0]   clr_col;
  logic          last_px;
  logic          enter_clear;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign plot_ready = !fifo_full && !clr_pend && (state != CLEAR);
  assign push       = plot_valid && plot_ready;

  assign rd_dat   = mem[rd_ptr];
  assign rd_x     = rd_dat[29:22];
  assign rd_y     = rd_dat[21:15];
  assign in_range = (int'(rd_x) < X_LIMIT) && (int'(rd_y) < Y_LIMIT);

  assign last_px     = (cx == 8'(X_LIMIT - 1)) && (cy == 7'(Y_LIMIT - 1));
  assign enter_clear = (state != CLEAR) && (state_nxt == CLEAR);

  // The clear write on vga_* lags the CLEAR state by one cycle. clr_wr keeps
  // busy high through the final write, so busy falls in the cycle after it.
  assign busy = !fifo_empty || clr_pend || (state == CLEAR) || clr_wr;

  // Next state and pop. The FIFO is drained before a pending clear starts, so a
  // plot accepted together with clear_start is plotted first.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty)   state_nxt = DRAIN;
        else if (clr_pend) state_nxt = CLEAR;
      end
      DRAIN: begin
        if (!fifo_empty)   pop       = 1'b1;
        else if (clr_pend) state_nxt = CLEAR;
        else               state_nxt = IDLE;
      end
      CLEAR: begin
        if (last_px)       state_nxt = IDLE;
      end
      default:             state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // FIFO storage does not need a reset. It is only read behind a non-zero count.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {plot_x, plot_y, plot_color};
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A clear request made while one is pending or running is ignored.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      clr_pend <= 1'b0;
    end else if (enter_clear) begin
      clr_pend <= 1'b0;
    end else if (clear_start && (state != CLEAR)) begin
      clr_pend <= 1'b1;
    end
  end

  // Sweep counters. x runs fastest. The fill colour is captured on entry.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cx      <= '0;
      cy      <= '0;
      clr_col <= '0;
    end else if (enter_clear) begin
      cx      <= '0;
      cy      <= '0;
      clr_col <= clear_color;
    end else if (state == CLEAR) begin
      if (cx == 8'(X_LIMIT - 1)) begin
        cx <= '0;
        cy <= cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end

  // Registered adapter port. Coordinates and colour hold whenever vga_plot=0.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      vga_x       <= '0;
      vga_y       <= '0;
      vga_color   <= '0;
      vga_plot    <= 1'b0;
      clr_wr      <= 1'b0;
      range_error <= 1'b0;
    end else begin
      vga_plot <= 1'b0;
      clr_wr   <= 1'b0;
      if (pop) begin
        if (in_range) begin
          vga_x     <= rd_x;
          vga_y     <= rd_y;
          vga_color <= rd_dat[14:0];
          vga_plot  <= 1'b1;
        end else begin
          range_error <= 1'b1;
        end
      end else if (state == CLEAR) begin
        vga_x     <= cx;
        vga_y     <= cy;
        vga_color <= clr_col;
        vga_plot  <= 1'b1;
        clr_wr    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_plot_sequencer.sv
module tb_vga_plot_sequencer;

  localparam int XL = 160;
  localparam int YL = 120;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        plot_valid = 1'b0;
  logic        plot_ready;
  logic [7:0]  plot_x = '0;
  logic [6:0]  plot_y = '0;
  logic [14:0] plot_color = '0;
  logic        clear_start = 1'b0;
  logic [14:0] clear_color = '0;
  logic        busy;
  logic        range_error;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [14:0] vga_color;
  logic        vga_plot;

  vga_plot_sequencer #(.FIFO_DEPTH(4), .X_LIMIT(XL), .Y_LIMIT(YL)) dut (
    .clock(clock), .resetn(resetn),
    .plot_valid(plot_valid), .plot_ready(plot_ready),
    .plot_x(plot_x), .plot_y(plot_y), .plot_color(plot_color),
    .clear_start(clear_start), .clear_color(clear_color),
    .busy(busy), .range_error(range_error),
    .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color), .vga_plot(vga_plot)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  // Reference model: the ordered list of pixel writes the screen should receive.
  logic [29:0] exp_q[$];
  logic [29:0] got_q[$];
  int          got_t[$];
  logic        exp_err = 1'b0;
  logic        clr_out = 1'b0;

  task automatic model_reset();
    exp_q.delete();
    got_q.delete();
    got_t.delete();
    exp_err = 1'b0;
    clr_out = 1'b0;
  endtask

  // Advance one clock. Capture what the handshake accepted, extend the model,
  // and record any write the DUT made. Sampling happens 1 time unit after the edge.
  task automatic step();
    logic acc, clr;
    logic [7:0] sx;
    logic [6:0] sy;
    logic [14:0] sc, scc;
    acc = plot_valid && plot_ready && resetn;
    clr = clear_start && !clr_out && resetn;
    sx = plot_x; sy = plot_y; sc = plot_color; scc = clear_color;
    @(posedge clock);
    #1;
    cyc_cnt++;
    if (acc) begin
      if (sx >= XL || sy >= YL) exp_err = 1'b1;
      else exp_q.push_back({sx, sy, sc});
    end
    if (clr) begin
      clr_out = 1'b1;
      for (int yy = 0; yy < YL; yy++)
        for (int xx = 0; xx < XL; xx++)
          exp_q.push_back({8'(xx), 7'(yy), scc});
    end
    if (vga_plot === 1'b1) begin
      got_q.push_back({vga_x, vga_y, vga_color});
      got_t.push_back(cyc_cnt);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0; plot_valid = 1'b0; clear_start = 1'b0;
    step(); step();
    resetn = 1'b1;
    model_reset();
  endtask

  function automatic int first_diff();
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
    if (got_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic logic [29:0] got_at(int i);
    return (i < got_q.size()) ? got_q[i] : 30'h0;
  endfunction

  function automatic logic [29:0] exp_at(int i);
    return (i < exp_q.size()) ? exp_q[i] : 30'h0;
  endfunction

  task automatic test_reset();
    resetn = 1'b0; plot_valid = 1'b0; clear_start = 1'b0;
    step(); step();
    checks++; if (vga_plot !== 1'b0) begin errors++; $display("FAIL reset_vga_plot got %b want 0", vga_plot); end
    checks++; if (vga_x !== 8'd0) begin errors++; $display("FAIL reset_vga_x got %0d want 0", vga_x); end
    checks++; if (vga_y !== 7'd0) begin errors++; $display("FAIL reset_vga_y got %0d want 0", vga_y); end
    checks++; if (vga_color !== 15'd0) begin errors++; $display("FAIL reset_vga_color got %h want 0", vga_color); end
    checks++; if (range_error !== 1'b0) begin errors++; $display("FAIL reset_range_error got %b want 0", range_error); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (plot_ready !== 1'b1) begin errors++; $display("FAIL reset_plot_ready got %b want 1", plot_ready); end
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic test_single_plot(string tag, bit with_reset);
    if (with_reset) do_reset();
    plot_x = 8'd10; plot_y = 7'd20; plot_color = 15'h7C00; plot_valid = 1'b1;
    checks++; if (plot_ready !== 1'b1) begin errors++; $display("FAIL %s_ready got %b want 1", tag, plot_ready); end
    step();
    plot_valid = 1'b0;
    checks++; if (vga_plot !== 1'b0) begin errors++; $display("FAIL %s_cyc1 vga_plot got %b want 0", tag, vga_plot); end
    step();
    checks++; if (vga_plot !== 1'b0) begin errors++; $display("FAIL %s_cyc2 vga_plot got %b want 0", tag, vga_plot); end
    step();
    checks++;
    if (vga_plot !== 1'b1 || vga_x !== 8'd10 || vga_y !== 7'd20 || vga_color !== 15'h7C00) begin
      errors++;
      $display("FAIL %s_cyc3 got plot=%b x=%0d y=%0d c=%h want plot=1 x=10 y=20 c=7c00",
               tag, vga_plot, vga_x, vga_y, vga_color);
    end
    step();
    checks++; if (vga_plot !== 1'b0) begin errors++; $display("FAIL %s_cyc4 vga_plot got %b want 0", tag, vga_plot); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy got %b want 0", tag, busy); end
  endtask

  task automatic test_back_to_back();
    int sent, t0, d, gap;
    logic acc;
    do_reset();
    sent = 0; t0 = -1;
    plot_x = 8'($urandom_range(0, XL - 1));
    plot_y = 7'($urandom_range(0, YL - 1));
    plot_color = 15'($urandom);
    plot_valid = 1'b1;
    for (int k = 0; k < 40 && sent < 6; k++) begin
      acc = plot_ready;
      step();
      if (acc) begin
        if (t0 < 0) t0 = cyc_cnt;
        sent++;
        plot_x = 8'($urandom_range(0, XL - 1));
        plot_y = 7'($urandom_range(0, YL - 1));
        plot_color = 15'($urandom);
      end
    end
    plot_valid = 1'b0;
    for (int k = 0; k < 12; k++) step();
    checks++; if (sent != 6) begin errors++; $display("FAIL b2b_sent got %0d want 6", sent); end
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL b2b_stream idx %0d got %h want %h (got %0d writes, want %0d)",
               d, got_at(d), exp_at(d), got_q.size(), exp_q.size());
    end
    checks++;
    if (got_t.size() == 0 || got_t[0] != t0 + 2) begin
      errors++;
      $display("FAIL b2b_latency first write at cycle %0d want %0d",
               (got_t.size() > 0) ? got_t[0] : -1, t0 + 2);
    end
    gap = -1;
    for (int i = 1; i < got_t.size(); i++) if (gap < 0 && got_t[i] != got_t[i-1] + 1) gap = i;
    checks++; if (gap != -1) begin errors++; $display("FAIL b2b_gap write %0d not consecutive, got gap at index %0d want none", gap, gap); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy got %b want 0", busy); end
  endtask

  task automatic test_range();
    int d;
    do_reset();
    plot_x = 8'd160; plot_y = 7'd5; plot_color = 15'h1234; plot_valid = 1'b1;
    step();
    plot_x = 8'd0; plot_y = 7'd119; plot_color = 15'h0ABC;
    step();
    plot_valid = 1'b0;
    for (int k = 0; k < 8; k++) step();
    checks++; if (range_error !== exp_err) begin errors++; $display("FAIL range_set got %b want %b", range_error, exp_err); end
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL range_stream idx %0d got %h want %h (got %0d writes, want %0d)",
               d, got_at(d), exp_at(d), got_q.size(), exp_q.size());
    end
    for (int k = 0; k < 10; k++) step();
    checks++; if (range_error !== 1'b1) begin errors++; $display("FAIL range_sticky got %b want 1", range_error); end
  endtask

  task automatic test_clear();
    int d, gap, target;
    bit retried;
    logic [29:0] last;
    do_reset();
    clear_color = 15'h001F;
    plot_x = 8'($urandom_range(0, XL - 1)); plot_y = 7'($urandom_range(0, YL - 1));
    plot_color = 15'($urandom); plot_valid = 1'b1;
    step();
    plot_x = 8'($urandom_range(0, XL - 1)); plot_y = 7'($urandom_range(0, YL - 1));
    plot_color = 15'($urandom); clear_start = 1'b1;
    step();
    plot_valid = 1'b0; clear_start = 1'b0;
    checks++; if (plot_ready !== 1'b0) begin errors++; $display("FAIL clear_pending_ready got %b want 0", plot_ready); end
    target = 2 + XL * YL;
    retried = 0;
    for (int k = 0; k < XL * YL + 100 && got_q.size() < target; k++) begin
      step();
      clear_start = 1'b0;
      if (!retried && got_q.size() >= 102) begin
        retried = 1;
        checks++; if (plot_ready !== 1'b0) begin errors++; $display("FAIL clear_active_ready got %b want 0", plot_ready); end
        clear_start = 1'b1;
      end
    end
    clear_start = 1'b0;
    checks++;
    if (got_q.size() != target) begin
      errors++;
      $display("FAIL clear_timeout got %0d writes want %0d", got_q.size(), target);
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clear_busy_last got %b want 1", busy); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_busy_fall got %b want 0", busy); end
    checks++; if (vga_plot !== 1'b0) begin errors++; $display("FAIL clear_plot_after got %b want 0", vga_plot); end
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL clear_stream idx %0d got %h want %h (got %0d writes, want %0d)",
               d, got_at(d), exp_at(d), got_q.size(), exp_q.size());
    end
    gap = -1;
    for (int i = 3; i < got_t.size(); i++) if (gap < 0 && got_t[i] != got_t[i-1] + 1) gap = i;
    checks++; if (gap != -1) begin errors++; $display("FAIL clear_gap clear write at index %0d not consecutive, want none", gap); end
    last = got_at(got_q.size() - 1);
    checks++;
    if (last !== {8'd159, 7'd119, 15'h001F}) begin
      errors++;
      $display("FAIL clear_last got %h want %h", last, {8'd159, 7'd119, 15'h001F});
    end
    for (int k = 0; k < 6; k++) step();
    checks++; if (got_q.size() != target) begin errors++; $display("FAIL clear_retry_ignored got %0d writes want %0d", got_q.size(), target); end
  endtask

  task automatic test_reset_mid_clear();
    do_reset();
    plot_x = 8'd200; plot_y = 7'd3; plot_color = 15'h5555; plot_valid = 1'b1;
    step();
    plot_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    checks++; if (range_error !== 1'b1) begin errors++; $display("FAIL midclr_range_pre got %b want 1", range_error); end
    clear_color = 15'($urandom);
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    for (int k = 0; k < 2000 && got_q.size() < 500; k++) step();
    checks++; if (got_q.size() != 500) begin errors++; $display("FAIL midclr_timeout got %0d writes want 500", got_q.size()); end
    resetn = 1'b0;
    step();
    checks++; if (vga_plot !== 1'b0) begin errors++; $display("FAIL midclr_vga_plot got %b want 0", vga_plot); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midclr_busy got %b want 0", busy); end
    checks++; if (range_error !== 1'b0) begin errors++; $display("FAIL midclr_range got %b want 0", range_error); end
    checks++; if (plot_ready !== 1'b1) begin errors++; $display("FAIL midclr_ready got %b want 1", plot_ready); end
    resetn = 1'b1;
    model_reset();
    for (int k = 0; k < 30; k++) step();
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL midclr_quiet got %0d writes want 0", got_q.size()); end
    test_single_plot("post_reset", 1'b0);
  endtask

  task automatic test_random();
    int d;
    do_reset();
    for (int k = 0; k < 300; k++) begin
      plot_valid = ($urandom_range(0, 9) < 7);
      plot_x = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(XL, 255)) : 8'($urandom_range(0, XL - 1));
      plot_y = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(YL, 127)) : 7'($urandom_range(0, YL - 1));
      plot_color = 15'($urandom);
      step();
    end
    plot_valid = 1'b0;
    for (int k = 0; k < 12; k++) step();
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL rand_stream idx %0d got %h want %h (got %0d writes, want %0d)",
               d, got_at(d), exp_at(d), got_q.size(), exp_q.size());
    end
    checks++; if (range_error !== exp_err) begin errors++; $display("FAIL rand_range got %b want %b", range_error, exp_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_busy got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single_plot("single", 1'b1);
    test_back_to_back();
    test_range();
    test_clear();
    test_reset_mid_clear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_plot_sequencer.md
VGA_PLOT_SEQUENCER -- requirements
Module: vga_plot_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of buffered plot commands (power of two, 2..16).
REQ-002 SHALL have parameter X_LIMIT, default 160, first illegal x coordinate.
REQ-003 SHALL have parameter Y_LIMIT, default 120, first illegal y coordinate.
REQ-004 SHALL have port clock  in  1  system clock; all state updates on rising edge.
REQ-005 SHALL have port resetn  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port plot_valid  in  1  plot command offered.
REQ-007 SHALL have port plot_ready  out  1  command accepted when plot_valid & plot_ready at a rising edge.
REQ-008 SHALL have port plot_x  in  8  pixel column.
REQ-009 SHALL have port plot_y  in  7  pixel row.
REQ-010 SHALL have port plot_color  in  15  pixel colour, 5:5:5.
REQ-011 SHALL have port clear_start  in  1  single-cycle full-screen clear request.
REQ-012 SHALL have port clear_color  in  15  fill colour, sampled when the clear begins.
REQ-013 SHALL have port busy  out  1  FIFO non-empty, clear pending, or clear active.
REQ-014 SHALL have port range_error  out  1  sticky: an out-of-range command was dropped.
REQ-015 SHALL have ports vga_x out 8, vga_y out 7, vga_color out 15, vga_plot out 1: registered adapter write port; pixel written when vga_plot=1.

Function
REQ-016 SHALL buffer accepted commands {x,y,color} in a FIFO_DEPTH-entry FIFO, strict arrival order.
REQ-017 SHALL drive plot_ready = FIFO not full AND no clear pending AND state != CLEAR; ready SHALL NOT depend on a same-cycle pop.
REQ-018 SHALL implement states IDLE, DRAIN, CLEAR: IDLE->DRAIN when FIFO non-empty; DRAIN->IDLE when FIFO empties and no clear pending; IDLE or DRAIN->CLEAR when clear pending and FIFO empty; CLEAR->IDLE after final pixel.
REQ-019 In DRAIN SHALL pop one entry per cycle and register it to vga_x/vga_y/vga_color with vga_plot=1 the following cycle.
REQ-020 Latency: command accepted at edge N into empty FIFO SHALL appear with vga_plot=1 during the cycle after edge N+2; sustained throughput one pixel per cycle.
REQ-021 Popped entry with x >= X_LIMIT or y >= Y_LIMIT SHALL be discarded (vga_plot=0 that cycle) and SHALL set range_error, held until reset.
REQ-022 clear_start SHALL set a pending flag; pending clear SHALL wait for FIFO drain; clear_start while pending or in CLEAR SHALL be ignored.
REQ-023 CLEAR SHALL sample clear_color on entry and emit X_LIMIT*Y_LIMIT writes (19200 default), one per cycle, x fastest 0..X_LIMIT-1, then y 0..Y_LIMIT-1; final write (159,119).
REQ-024 Simultaneous clear_start and plot_valid in a ready cycle: the plot SHALL be accepted and plotted before the clear.
REQ-025 vga_plot SHALL be 0 in IDLE; vga_x/vga_y/vga_color SHALL hold last values when vga_plot=0.

Reset
REQ-026 resetn=0 at a rising edge SHALL empty the FIFO, clear pending flag, enter IDLE, zero sweep counters, and drive vga_plot=0, vga_x=0, vga_y=0, vga_color=0, range_error=0, busy=0, plot_ready=1 (next cycle).
REQ-027 Reset mid-clear or mid-drain SHALL abort immediately; no further vga_plot pulses until new commands.

Verification
REQ-028 Single plot (10,20,15'h7C00) into idle -> vga_plot=1 exactly one cycle, 3rd cycle after handshake, outputs 10/20/7C00.
REQ-029 Push 6 commands back-to-back with ready honoured -> plot_ready low when 4 buffered; all 6 emitted in order, no gaps once draining.
REQ-030 Command (160,5) then (0,119) -> first dropped, range_error=1 stays set; second plotted.
REQ-031 clear_start with clear_color=15'h001F and 2 queued plots -> both plots emitted, then 19200 consecutive writes colour 001F, last (159,119), busy falls next cycle.
REQ-032 resetn=0 at clear pixel 500 -> vga_plot=0, busy=0, range_error=0 following cycle; fresh plot then behaves as REQ-028.
